mux41_rr_sel: RTL



---
 rtl/mux41_rr_sel.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mux41_rr_sel.sv
// -----------------------------------------------------------------------------
// mux41_rr_sel
//
// Round-robin select sequencer for a downstream 4:1 mux. Arbitrates among four
// request lines, drives the mux select pair {s1,s2}, a one-hot grant and a
// valid flag. A granted channel is held for at least DWELL cycles while others
// compete (or indefinitely while lock is high). Every release inserts one dead
// cycle (GAP) so the mux output can settle before the next grant.
//
// Parameters:
//   DWELL  minimum grant length before a competing request may take over (1..255)
//   CW     dwell counter width, 2**CW > DWELL
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [3:0] per-channel request (req[0]=a .. req[3]=d)
//   lock   in   hold the current grant regardless of dwell/request state
//   s1     out  mux select MSB (registered)
//   s2     out  mux select LSB (registered); {s1,s2} = granted channel
//   gnt    out  [3:0] one-hot grant (registered), 0 when nothing granted
//   valid  out  grant active and mux output usable (registered)
// -----------------------------------------------------------------------------
module mux41_rr_sel #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       lock,
    output logic       s1,
    output logic       s2,
    output logic [3:0] gnt,
    output logic       valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CW-1:0] DWELL_C    = CW'(DWELL);
    localparam logic [CW-1:0] DWELL_M1_C = CW'(DWELL - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [1:0]    last_q,  last_d;
    logic [1:0]    sel_q,   sel_d;
    logic [3:0]    gnt_q,   gnt_d;
    logic          valid_q, valid_d;

    logic [1:0]    winner;
    logic          any_req;
    logic          other_req;
    logic          release_grant;

    // First requester scanning last+1, last+2, last+3, last (mod 4). The loop
    // runs from the farthest offset down so the nearest requester overwrites.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign winner    = rr_pick(req, last_q);
    assign any_req   = |req;
    assign other_req = |(req & ~gnt_q);

    // The current channel is sel_q; it stays valid through GRANT.
    assign release_grant = !lock &&
                           (!req[sel_q] || ((cnt_q >= DWELL_M1_C) && other_req));

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path
        // through the case below can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;

        case (state_q)
            IDLE, GAP: begin
                if (any_req) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    gnt_d   = 4'b0001 << winner;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end

            GRANT: begin
                // Saturate at DWELL so a long lock never wraps the counter.
                if (cnt_q != DWELL_C) cnt_d = cnt_q + 1'b1;
                if (release_grant) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    last_d  = sel_q;   // select stays put through the gap
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // last resets to 3 so channel 0 has first priority out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd3;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from the values sampled at this edge.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign s1    = sel_q[1];
    assign s2    = sel_q[0];
    assign gnt   = gnt_q;
    assign valid = valid_q;

endmodule
